hyper_mvblck_frdram_p: RTL and testbench



---
 rtl/hyper_mvblck_frdram_p.sv | 148 ++++++++++++++
 tb/tb_hyper_mvblck_frdram_p.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mvblck_frdram_p.sv
// Parametrised DRAM-to-LSAB block mover: streams an aligned column burst to one MCU
// and writes only the requested words. Optional macro HYPER_MVBLCK_RESUME_EN adds RESUME.
module hyper_mvblck_frdram_p #(
    parameter int ADDR_W     = 12,
    parameter int CNT_W      = 6,
    parameter int SECT_LOG2  = 2,
    parameter int SEL_W      = 2,
    parameter int RD_LAT     = 6,
    parameter int ALIGN_LOG2 = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [(1<<SECT_LOG2)-1:0]   LSAB_FULL,
    output logic                        LSAB_WRITE,
    output logic [SECT_LOG2-1:0]        LSAB_SECTION,
    input  logic [ADDR_W-1:0]           START_ADDRESS,
    input  logic [CNT_W-1:0]            COUNT_REQ,
    input  logic [SECT_LOG2-1:0]        SECTION,
    input  logic [SEL_W-1:0]            DRAM_SEL,
    input  logic                        ISSUE,
`ifdef HYPER_MVBLCK_RESUME_EN
    input  logic                        RESUME,
`endif
    output logic [CNT_W-1:0]            COUNT_SENT,
    output logic                        WORKING,
    output logic                        ABRUPT_STOP,
    output logic [ADDR_W-1:0]           MCU_COLL_ADDRESS,
    output logic [SEL_W-1:0]            MCU_REQUEST_ACCESS
);

    localparam int BW = CNT_W + ALIGN_LOG2 + 1;
    localparam logic [ADDR_W-1:0] ADDR_ALIGN_M1 = ADDR_W'((1 << ALIGN_LOG2) - 1);
    localparam logic [BW-1:0]     BEAT_ALIGN_M1 = BW'((1 << ALIGN_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [SEL_W-1:0]      sel_q;
    logic [SECT_LOG2-1:0]  sect_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [BW-1:0]         first_q, last_q, beats_q, idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  abrupt_q;
    logic [RD_LAT-1:0]     dl;
    logic [SEL_W-1:0]      req;

    logic                  full_now, accept, resume_go, beat, more, last_beat, beat_valid, dl_empty;
    logic [BW-1:0]         start_off, last_calc, beats_calc;

    assign full_now   = LSAB_FULL[sect_q];
    assign accept     = (state == IDLE) && ISSUE && (DRAM_SEL != '0);
    assign beat       = (state == READ) && !full_now;
    assign more       = (idx_q + BW'(1)) < beats_q;
    assign last_beat  = beat && !more;
    // Padding beats at either end of the aligned burst carry a zero valid bit.
    assign beat_valid = beat && (idx_q >= first_q) && (idx_q <= last_q);
    assign dl_empty   = (dl == '0);

    assign start_off  = BW'(START_ADDRESS & ADDR_ALIGN_M1);
    assign last_calc  = start_off + BW'(COUNT_REQ);
    assign beats_calc = (last_calc + BW'(1) + BEAT_ALIGN_M1) & ~BEAT_ALIGN_M1;

`ifdef HYPER_MVBLCK_RESUME_EN
    logic resumable_q;
    assign resume_go = (state == IDLE) && !accept && RESUME && resumable_q;
`else
    assign resume_go = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req       = '0;
        case (state)
            IDLE: begin
                req = DRAM_SEL & {SEL_W{ISSUE}};
                if (resume_go) req = sel_q;
                if (accept || resume_go) state_nxt = READ;
            end
            READ: begin
                req = sel_q & {SEL_W{more && !full_now}};
                if (full_now || last_beat) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (dl_empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            sel_q    <= '0;
            sect_q   <= '0;
            addr_q   <= '0;
            first_q  <= '0;
            last_q   <= '0;
            beats_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            abrupt_q <= 1'b0;
            dl       <= '0;
        end else begin
            state <= state_nxt;
            dl    <= {dl[RD_LAT-2:0], beat_valid};
            if (LSAB_WRITE) cnt_q <= cnt_q + CNT_W'(1);
            if (beat) begin
                addr_q <= addr_q + ADDR_W'(1);
                idx_q  <= idx_q + BW'(1);
            end
            if ((state == READ) && full_now) abrupt_q <= 1'b1;
            if (resume_go) abrupt_q <= 1'b0;
            if (accept) begin
                sel_q    <= DRAM_SEL;
                sect_q   <= SECTION;
                addr_q   <= START_ADDRESS & ~ADDR_ALIGN_M1;
                first_q  <= start_off;
                last_q   <= last_calc;
                beats_q  <= beats_calc;
                idx_q    <= '0;
                cnt_q    <= '0;
                abrupt_q <= 1'b0;
            end
        end
    end

`ifdef HYPER_MVBLCK_RESUME_EN
    // Only an abrupt stop leaves a burst that RESUME may continue.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            resumable_q <= 1'b0;
        end else if (accept || resume_go) begin
            resumable_q <= 1'b0;
        end else if ((state == READ) && full_now) begin
            resumable_q <= 1'b1;
        end
    end
`endif

    assign LSAB_WRITE         = dl[RD_LAT-1];
    assign LSAB_SECTION       = sect_q;
    assign COUNT_SENT         = cnt_q;
    assign WORKING            = (state != IDLE);
    assign ABRUPT_STOP        = abrupt_q;
    assign MCU_COLL_ADDRESS   = addr_q;
    assign MCU_REQUEST_ACCESS = req & {SEL_W{RST}};

endmodule

// File: tb/tb_hyper_mvblck_frdram_p.sv
// Self-checking bench for hyper_mvblck_frdram_p (default build, no resume port).
module tb_hyper_mvblck_frdram_p;

    localparam int RD_LAT = 6;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  LSAB_FULL = '0;
    logic        LSAB_WRITE;
    logic [1:0]  LSAB_SECTION;
    logic [11:0] START_ADDRESS = '0;
    logic [5:0]  COUNT_REQ = '0;
    logic [1:0]  SECTION = '0;
    logic [1:0]  DRAM_SEL = '0;
    logic        ISSUE = 1'b0;
    logic [5:0]  COUNT_SENT;
    logic        WORKING;
    logic        ABRUPT_STOP;
    logic [11:0] MCU_COLL_ADDRESS;
    logic [1:0]  MCU_REQUEST_ACCESS;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_addr_after = '0;

    int          beat_cyc[$];
    logic [11:0] beat_addr[$];
    int          wr_cyc[$];

    always #5 CLK = ~CLK;

    hyper_mvblck_frdram_p dut (
        .CLK(CLK), .RST(RST), .LSAB_FULL(LSAB_FULL), .LSAB_WRITE(LSAB_WRITE),
        .LSAB_SECTION(LSAB_SECTION), .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ),
        .SECTION(SECTION), .DRAM_SEL(DRAM_SEL), .ISSUE(ISSUE), .COUNT_SENT(COUNT_SENT),
        .WORKING(WORKING), .ABRUPT_STOP(ABRUPT_STOP), .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS),
        .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS)
    );

    // One transfer: the request lines lead each beat by a cycle, so a beat is the cycle
    // after a non-zero request unless the target section is full in that cycle.
    task automatic run_transfer(input logic [11:0] start, input logic [5:0] cnt,
                                input logic [1:0] sect, input logic [1:0] sel,
                                input int full_after, input bit issue_mid,
                                input logic [3:0] other_full, input string name);
        int off, total, n, first_w, last_w, nw, fall, full_cyc, bad_req;
        bit prev_req, fullset, abrupt;
        logic [1:0] full_req;
        logic [11:0] aligned;
        int exp_w[$];
        beat_cyc.delete(); beat_addr.delete(); wr_cyc.delete();
        off     = int'(start[0]);
        aligned = {start[11:1], 1'b0};
        total   = ((off + int'(cnt) + 2) / 2) * 2;
        abrupt  = (full_after >= 0);
        n       = abrupt ? full_after : total;
        first_w = off;
        last_w  = off + int'(cnt);
        for (int k = 0; k < n; k++)
            if (k >= first_w && k <= last_w) exp_w.push_back(k + 1 + RD_LAT);
        nw = exp_w.size();

        @(negedge CLK);
        START_ADDRESS = start; COUNT_REQ = cnt; SECTION = sect; DRAM_SEL = sel; ISSUE = 1'b1;
        LSAB_FULL = other_full & ~(4'b1 << sect);
        #1;
        checks++;
        if (MCU_REQUEST_ACCESS !== sel) begin
            errors++;
            $display("[TB] FAIL %s req_accept got %b want %b", name, MCU_REQUEST_ACCESS, sel);
        end
        prev_req = (MCU_REQUEST_ACCESS != 2'b00);
        fall = -1; fullset = 0; full_cyc = -1; full_req = 2'bxx; bad_req = 0;
        for (int c = 1; c < 400 && fall < 0; c++) begin
            @(negedge CLK);
            ISSUE = 1'b0;
            if (issue_mid && c == 2) begin
                ISSUE = 1'b1; START_ADDRESS = 12'h555; DRAM_SEL = ~sel; SECTION = sect + 2'd1;
            end
            if (abrupt && !fullset && beat_cyc.size() == full_after) begin
                LSAB_FULL[sect] = 1'b1; fullset = 1; full_cyc = c;
            end
            #1;
            if (prev_req && !LSAB_FULL[sect]) begin
                beat_cyc.push_back(c);
                beat_addr.push_back(MCU_COLL_ADDRESS);
            end
            if (c == full_cyc) full_req = MCU_REQUEST_ACCESS;
            if (MCU_REQUEST_ACCESS != 2'b00 && MCU_REQUEST_ACCESS !== sel) bad_req++;
            if (LSAB_WRITE) wr_cyc.push_back(c);
            if (!WORKING) fall = c;
            prev_req = (MCU_REQUEST_ACCESS != 2'b00);
        end
        ISSUE = 1'b0; LSAB_FULL = '0;

        checks++;
        if (fall < 0) begin
            errors++;
            $display("[TB] FAIL %s timeout WORKING never fell", name);
        end
        checks++;
        if (beat_cyc.size() != n) begin
            errors++;
            $display("[TB] FAIL %s beat_count got %0d want %0d", name, beat_cyc.size(), n);
        end
        for (int k = 0; k < n && k < beat_cyc.size(); k++) begin
            checks++;
            if (beat_addr[k] !== 12'(aligned + 12'(k)) || beat_cyc[k] != k + 1) begin
                errors++;
                $display("[TB] FAIL %s beat%0d got addr %h cyc %0d want addr %h cyc %0d",
                         name, k, beat_addr[k], beat_cyc[k], 12'(aligned + 12'(k)), k + 1);
            end
        end
        checks++;
        if (wr_cyc.size() != nw) begin
            errors++;
            $display("[TB] FAIL %s write_count got %0d want %0d", name, wr_cyc.size(), nw);
        end
        for (int k = 0; k < nw && k < wr_cyc.size(); k++) begin
            checks++;
            if (wr_cyc[k] != exp_w[k]) begin
                errors++;
                $display("[TB] FAIL %s write%0d cycle got %0d want %0d", name, k, wr_cyc[k], exp_w[k]);
            end
        end
        checks++;
        if (COUNT_SENT !== 6'(nw)) begin
            errors++;
            $display("[TB] FAIL %s count_sent got %0d want %0d", name, COUNT_SENT, nw);
        end
        checks++;
        if (ABRUPT_STOP !== abrupt) begin
            errors++;
            $display("[TB] FAIL %s abrupt got %b want %b", name, ABRUPT_STOP, abrupt);
        end
        checks++;
        if (LSAB_SECTION !== sect) begin
            errors++;
            $display("[TB] FAIL %s section got %0d want %0d", name, LSAB_SECTION, sect);
        end
        checks++;
        if (fall != (nw > 0 ? exp_w[nw-1] + 2 : n + 3)) begin
            errors++;
            $display("[TB] FAIL %s working_fall got %0d want %0d", name, fall,
                     nw > 0 ? exp_w[nw-1] + 2 : n + 3);
        end
        checks++;
        if (bad_req != 0) begin
            errors++;
            $display("[TB] FAIL %s req_lines got %0d foreign cycles want 0", name, bad_req);
        end
        if (abrupt) begin
            checks++;
            if (full_req !== 2'b00) begin
                errors++;
                $display("[TB] FAIL %s req_on_full got %b want 00", name, full_req);
            end
        end
        exp_addr_after = 12'(aligned + 12'(n));
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b0; ISSUE = 1'b1; DRAM_SEL = 2'b01;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if ({LSAB_WRITE, LSAB_SECTION, COUNT_SENT, WORKING, ABRUPT_STOP, MCU_COLL_ADDRESS,
             MCU_REQUEST_ACCESS} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got req %b addr %h cnt %0d work %b want all 0",
                     MCU_REQUEST_ACCESS, MCU_COLL_ADDRESS, COUNT_SENT, WORKING);
        end
        ISSUE = 1'b0; DRAM_SEL = 2'b00; RST = 1'b1;
    endtask

    task automatic test_basic();
        run_transfer(12'h010, 6'd3, 2'd1, 2'b01, -1, 0, 4'b0000, "basic");
    endtask

    task automatic test_unaligned();
        run_transfer(12'h011, 6'd1, 2'd1, 2'b01, -1, 0, 4'b0000, "unaligned");
    endtask

    task automatic test_full();
        run_transfer(12'h020, 6'd15, 2'd2, 2'b01, 5, 0, 4'b0000, "full_stop");
    endtask

    task automatic test_wrap();
        run_transfer(12'hFFE, 6'd3, 2'd0, 2'b10, -1, 0, 4'b0000, "wrap");
    endtask

    task automatic test_ignored_issue();
        run_transfer(12'h101, 6'd6, 2'd3, 2'b10, -1, 1, 4'b0111, "issue_mid");
        @(negedge CLK);
        ISSUE = 1'b1; DRAM_SEL = 2'b00; START_ADDRESS = 12'h3C0;
        #1;
        checks++;
        if (MCU_REQUEST_ACCESS !== 2'b00) begin
            errors++;
            $display("[TB] FAIL sel0_req got %b want 00", MCU_REQUEST_ACCESS);
        end
        @(negedge CLK);
        ISSUE = 1'b0;
        #1;
        checks++;
        if (WORKING !== 1'b0 || MCU_COLL_ADDRESS !== exp_addr_after) begin
            errors++;
            $display("[TB] FAIL sel0_ignored got work %b addr %h want work 0 addr %h",
                     WORKING, MCU_COLL_ADDRESS, exp_addr_after);
        end
    endtask

    task automatic test_reset_mid();
        int beats;
        bit prev_req, done, wrote;
        @(negedge CLK);
        START_ADDRESS = 12'h040; COUNT_REQ = 6'd15; SECTION = 2'd3; DRAM_SEL = 2'b10; ISSUE = 1'b1;
        #1;
        prev_req = (MCU_REQUEST_ACCESS != 2'b00);
        beats = 0; done = 0;
        for (int c = 1; c < 40 && !done; c++) begin
            @(negedge CLK);
            ISSUE = 1'b0;
            if (beats == 3) begin
                RST = 1'b0;
                #1;
                checks++;
                if (MCU_REQUEST_ACCESS !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL rst_mid_req got %b want 00", MCU_REQUEST_ACCESS);
                end
                done = 1;
            end else begin
                #1;
                if (prev_req) beats++;
                prev_req = (MCU_REQUEST_ACCESS != 2'b00);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL rst_mid_timeout got %0d beats want 3", beats);
        end
        @(negedge CLK);
        #1;
        checks++;
        if ({LSAB_WRITE, LSAB_SECTION, COUNT_SENT, WORKING, ABRUPT_STOP, MCU_COLL_ADDRESS,
             MCU_REQUEST_ACCESS} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs got addr %h work %b sect %0d want all 0",
                     MCU_COLL_ADDRESS, WORKING, LSAB_SECTION);
        end
        RST = 1'b1;
        wrote = 0;
        repeat (12) begin
            @(negedge CLK);
            #1;
            if (LSAB_WRITE || WORKING) wrote = 1;
        end
        checks++;
        if (wrote) begin
            errors++;
            $display("[TB] FAIL rst_mid_quiet got activity after reset want none");
        end
        run_transfer(12'h010, 6'd3, 2'd1, 2'b01, -1, 0, 4'b0000, "after_reset");
    endtask

    task automatic test_random();
        logic [11:0] start;
        logic [5:0]  cnt;
        int total, fa;
        for (int i = 0; i < 25; i++) begin
            start = 12'($urandom);
            cnt   = 6'($urandom_range(0, 63));
            total = ((int'(start[0]) + int'(cnt) + 2) / 2) * 2;
            fa    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            run_transfer(start, cnt, 2'($urandom_range(0, 3)), 2'($urandom_range(1, 2)), fa, 0,
                         4'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unaligned();
        test_full();
        test_wrap();
        test_ignored_issue();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
